// File: rtl/store_narrower.sv
`default_nettype none
// ============================================================================
// Module      : store_narrower
// Description : Store-side narrowing unit. Takes a 32-bit store word with an
//               access size and byte offset, narrows it to byte, halfword or
//               word, and issues one or two 16-bit beats to a halfword-wide
//               data memory port under a valid/ready handshake. Flags values
//               that a same-width sign-extending load would not reproduce, and
//               rejects misaligned or reserved-size requests.
// Revision    : 1.0 - initial release
// ============================================================================
module store_narrower (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_hsel_o,
  output logic [15:0] mem_data_o,
  output logic [1:0]  mem_be_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic        err_o
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Request-side decode
  logic        w_accept;
  logic        w_bad;
  logic        w_start;
  logic        w_ovf;

  // Beat-side decode
  logic        w_beat_fire;
  logic        w_last_fire;

  // First-beat values computed from the incoming request
  logic        w_b0_hsel;
  logic [15:0] w_b0_data;
  logic [1:0]  w_b0_be;

  // Registered request context and outputs
  logic        r_is_word;
  logic [15:0] r_hi_data;
  logic        r_mem_hsel;
  logic [15:0] r_mem_data;
  logic [1:0]  r_mem_be;
  logic        r_ovf;
  logic        r_err;
  logic        r_done;

  // Handshake, alignment check and overflow detection for the incoming request
  always_comb begin
    w_accept = req_valid_i & (r_state == ST_IDLE);
    w_bad    = (size_i == c_SIZE_RSVD)
             | ((size_i == c_SIZE_HALF) & addr_i[0])
             | ((size_i == c_SIZE_WORD) & (addr_i != 2'b00));
    w_start  = w_accept & ~w_bad;
    // A value survives a sign-extending reload only if every bit above the
    // narrowed sign bit equals that sign bit.
    case (size_i)
      c_SIZE_BYTE: w_ovf = ~((&data_i[31:7])  | ~(|data_i[31:7]));
      c_SIZE_HALF: w_ovf = ~((&data_i[31:15]) | ~(|data_i[31:15]));
      default:     w_ovf = 1'b0;
    endcase
  end

  // First beat placement: lane select, replicated byte and byte enables
  always_comb begin
    w_b0_hsel = 1'b0;
    w_b0_data = data_i[15:0];
    w_b0_be   = 2'b11;
    case (size_i)
      c_SIZE_BYTE: begin
        w_b0_hsel = addr_i[1];
        w_b0_data = {data_i[7:0], data_i[7:0]};
        w_b0_be   = addr_i[0] ? 2'b10 : 2'b01;
      end
      c_SIZE_HALF: begin
        w_b0_hsel = addr_i[1];
        w_b0_data = data_i[15:0];
        w_b0_be   = 2'b11;
      end
      default: begin
        w_b0_hsel = 1'b0;
        w_b0_data = data_i[15:0];
        w_b0_be   = 2'b11;
      end
    endcase
  end

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded handshake/status outputs
  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    mem_valid_o  = 1'b0;
    busy_o       = 1'b0;
    w_beat_fire  = 1'b0;
    w_last_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (w_start) begin
          w_state_next = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        mem_valid_o = 1'b1;
        busy_o      = 1'b1;
        if (mem_ready_i) begin
          w_beat_fire  = 1'b1;
          w_last_fire  = ~r_is_word;
          w_state_next = r_is_word ? ST_BEAT1 : ST_IDLE;
        end
      end
      ST_BEAT1: begin
        mem_valid_o = 1'b1;
        busy_o      = 1'b1;
        if (mem_ready_i) begin
          w_beat_fire  = 1'b1;
          w_last_fire  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Beat datapath, overflow flag and one-cycle status pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_is_word  <= 1'b0;
      r_hi_data  <= 16'h0000;
      r_mem_hsel <= 1'b0;
      r_mem_data <= 16'h0000;
      r_mem_be   <= 2'b00;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_err  <= w_accept & w_bad;
      r_done <= w_last_fire;
      if (w_start) begin
        r_is_word  <= (size_i == c_SIZE_WORD);
        r_hi_data  <= data_i[31:16];
        r_ovf      <= w_ovf;
        r_mem_hsel <= w_b0_hsel;
        r_mem_data <= w_b0_data;
        r_mem_be   <= w_b0_be;
      end else if (w_beat_fire) begin
        if (w_last_fire) begin
          // Park the beat lanes at zero once the request has drained.
          r_mem_hsel <= 1'b0;
          r_mem_data <= 16'h0000;
          r_mem_be   <= 2'b00;
        end else begin
          r_mem_hsel <= 1'b1;
          r_mem_data <= r_hi_data;
          r_mem_be   <= 2'b11;
        end
      end
    end
  end

  assign mem_hsel_o = r_mem_hsel;
  assign mem_data_o = r_mem_data;
  assign mem_be_o   = r_mem_be;
  assign ovf_o      = r_ovf;
  assign err_o      = r_err;
  assign done_o     = r_done;

endmodule
`default_nettype wire
